// File: rtl/button_press_conditioner.sv
// rtl/button_press_conditioner.sv - button synchroniser, debouncer and press/long/repeat pulse generator
// Produces clk-domain single-cycle events and a merged step enable for the LED counter.
module button_press_conditioner #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int LONG_PRESS_CYCLES = 25000000,
  parameter int REPEAT_CYCLES     = 5000000,
  parameter bit ACTIVE_LOW_BUTTON = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic step
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam int REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'((LONG_PRESS_CYCLES > 0) ? LONG_PRESS_CYCLES - 1 : 0);
  localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REPEAT_CYCLES - 1);
  localparam bit                LONG_EN  = (LONG_PRESS_CYCLES != 0);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    REPEAT,
    DB_RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
  logic                rep_flag_q, rep_flag_d;
  logic                level_q, level_d;
  logic                press_q, press_d;
  logic                release_q, release_d;
  logic                long_q, long_d;
  logic                repeat_q, repeat_d;
  logic                step_q;
  logic                s_in;

  // Polarity is normalised before the first flop so s_in = 1 always means pressed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button ^ ACTIVE_LOW_BUTTON};
    end
  end

  assign s_in = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      rep_flag_q <= 1'b0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      rep_flag_q <= rep_flag_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
      step_q     <= press_d | long_d | repeat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    rep_flag_d = rep_flag_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;

    case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (s_in) state_d = DB_PRESS;
      end
      DB_PRESS: begin
        if (!s_in) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_MAX) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      HELD: begin
        if (!s_in) begin
          state_d = DB_RELEASE;
        end else if (LONG_EN && hold_cnt_q == HOLD_MAX) begin
          state_d    = REPEAT;
          long_d     = 1'b1;
          rep_flag_d = 1'b1;
        end else if (LONG_EN) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      REPEAT: begin
        if (!s_in) begin
          state_d = DB_RELEASE;
        end else if (rep_cnt_q == REP_MAX) begin
          repeat_d  = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
      DB_RELEASE: begin
        level_d = 1'b1;
        if (s_in) begin
          state_d = rep_flag_q ? REPEAT : HELD;
        end else if (db_cnt_q == DB_MAX) begin
          state_d    = IDLE;
          level_d    = 1'b0;
          release_d  = 1'b1;
          rep_flag_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Every timer restarts from zero on entry to a new state.
    if (state_d != state_q) begin
      db_cnt_d   = '0;
      hold_cnt_d = '0;
      rep_cnt_d  = '0;
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign repeat_pulse  = repeat_q;
  assign step          = step_q;

endmodule

// File: tb/tb_button_press_conditioner.sv
// tb/tb_button_press_conditioner.sv - self-checking bench for button_press_conditioner
module tb_button_press_conditioner;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int LONG = 10;
  localparam int REP  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic button = 1'b0;
  logic button_n = 1'b1;

  logic level, press_pulse, release_pulse, long_press, repeat_pulse, step;
  logic level_n, press_n, release_n, long_n, repeat_n, step_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_press_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LONG),
    .REPEAT_CYCLES(REP), .ACTIVE_LOW_BUTTON(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .button(button),
    .level(level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_press(long_press), .repeat_pulse(repeat_pulse), .step(step)
  );

  button_press_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LONG),
    .REPEAT_CYCLES(REP), .ACTIVE_LOW_BUTTON(1'b1)
  ) dut_n (
    .clk(clk), .rst(rst), .button(button_n),
    .level(level_n), .press_pulse(press_n), .release_pulse(release_n),
    .long_press(long_n), .repeat_pulse(repeat_n), .step(step_n)
  );

  // Reference model: run lengths of the synchronised input plus time since entering the held phase.
  logic sync_m [SYNC];
  int   run1, run0, age;
  logic m_lvl, m_rep;
  logic e_press, e_rel, e_long, e_rep;
  int   n_press, n_rel, n_long, n_rep, n_step;

  typedef struct {
    logic btn;
    int   n;
    logic lvl;
    int   np;
    int   nr;
    int   nl;
    int   nrep;
    int   nstep;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) sync_m[i] = 1'b0;
    run1 = 0; run0 = 0; age = 0;
    m_lvl = 1'b0; m_rep = 1'b0;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rep = 1'b0;
  endtask

  task automatic model_step();
    logic s;
    s = sync_m[SYNC-1];
    for (int i = SYNC-1; i > 0; i--) sync_m[i] = sync_m[i-1];
    sync_m[0] = button;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rep = 1'b0;
    if (s) begin run1++; run0 = 0; end
    else begin run0++; run1 = 0; end
    if (!m_lvl) begin
      if (run1 == DB + 1) begin
        m_lvl = 1'b1; e_press = 1'b1; age = 0; m_rep = 1'b0;
      end
    end else if (!s) begin
      if (run0 == DB + 1) begin
        m_lvl = 1'b0; e_rel = 1'b1; m_rep = 1'b0;
      end
    end else if (run1 == 1) begin
      age = 0;
    end else begin
      age++;
      if (!m_rep) begin
        if (LONG != 0 && age == LONG) begin
          e_long = 1'b1; m_rep = 1'b1; age = 0;
        end
      end else if (age % REP == 0) begin
        e_rep = 1'b1;
      end
    end
  endtask

  task automatic cycle(input logic b);
    button = b;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("level", level, m_lvl);
    chk("press_pulse", press_pulse, e_press);
    chk("release_pulse", release_pulse, e_rel);
    chk("long_press", long_press, e_long);
    chk("repeat_pulse", repeat_pulse, e_rep);
    chk("step", step, e_press | e_long | e_rep);
    n_press += int'(press_pulse);
    n_rel   += int'(release_pulse);
    n_long  += int'(long_press);
    n_rep   += int'(repeat_pulse);
    n_step  += int'(step);
  endtask

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_long = 0; n_rep = 0; n_step = 0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 10, 1'b1, 1, 0, 0, 0, 1};
    tbl[1]  = '{1'b0, 10, 1'b0, 0, 1, 0, 0, 0};
    tbl[2]  = '{1'b1,  3, 1'b0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1'b0,  1, 1'b0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1'b1,  2, 1'b0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1'b0,  6, 1'b0, 0, 0, 0, 0, 0};
    tbl[6]  = '{1'b1, 10, 1'b1, 1, 0, 0, 0, 1};
    tbl[7]  = '{1'b0, 10, 1'b0, 0, 1, 0, 0, 0};
    tbl[8]  = '{1'b1, 40, 1'b1, 1, 0, 1, 7, 9};
    tbl[9]  = '{1'b0, 10, 1'b0, 0, 1, 0, 1, 1};
    tbl[10] = '{1'b1, 20, 1'b1, 1, 0, 1, 1, 3};
    tbl[11] = '{1'b0,  2, 1'b1, 0, 0, 0, 0, 0};
    tbl[12] = '{1'b1, 12, 1'b1, 0, 0, 0, 3, 3};
    tbl[13] = '{1'b0, 10, 1'b0, 0, 1, 0, 0, 0};

    model_reset();
    clear_counts();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_level", level, 1'b0);
    chk("reset_press", press_pulse, 1'b0);
    chk("reset_release", release_pulse, 1'b0);
    chk("reset_long", long_press, 1'b0);
    chk("reset_repeat", repeat_pulse, 1'b0);
    chk("reset_step", step, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      clear_counts();
      repeat (tbl[i].n) cycle(tbl[i].btn);
      chk_int($sformatf("row%0d_press", i), n_press, tbl[i].np);
      chk_int($sformatf("row%0d_release", i), n_rel, tbl[i].nr);
      chk_int($sformatf("row%0d_long", i), n_long, tbl[i].nl);
      chk_int($sformatf("row%0d_repeat", i), n_rep, tbl[i].nrep);
      chk_int($sformatf("row%0d_step", i), n_step, tbl[i].nstep);
      chk($sformatf("row%0d_level", i), level, tbl[i].lvl);
    end

    // Clean press and release at exact edges.
    for (int e = 1; e <= 12; e++) begin
      cycle(1'b1);
      chk("t1_press_edge", press_pulse, e == 7);
      chk("t1_level", level, e >= 7);
    end
    for (int e = 1; e <= 10; e++) begin
      cycle(1'b0);
      chk("t1_release_edge", release_pulse, e == 7);
      chk("t1_level_rel", level, e < 7);
    end

    // Long press then repeats every REP cycles; none once release debounce starts.
    for (int e = 1; e <= 40; e++) begin
      cycle(1'b1);
      chk("t3_press_edge", press_pulse, e == 7);
      chk("t3_long_edge", long_press, e == 17);
      chk("t3_repeat_edge", repeat_pulse, (e >= 20) && ((e - 20) % 3 == 0));
    end
    for (int e = 1; e <= 10; e++) begin
      cycle(1'b0);
      chk("t3_step_after_release", step, e == 1);
      chk("t3_release_edge", release_pulse, e == 7);
    end

    // Asynchronous reset while in REPEAT with the button held.
    repeat (20) cycle(1'b1);
    #2 rst = 1'b0;
    #1;
    chk("t5_level", level, 1'b0);
    chk("t5_press", press_pulse, 1'b0);
    chk("t5_release", release_pulse, 1'b0);
    chk("t5_long", long_press, 1'b0);
    chk("t5_repeat", repeat_pulse, 1'b0);
    chk("t5_step", step, 1'b0);
    model_reset();
    @(negedge clk);
    chk("t5_level_held", level, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      cycle(1'b1);
      chk("t5_press_edge", press_pulse, e == 7);
      chk("t5_no_release", release_pulse, 1'b0);
    end
    repeat (10) cycle(1'b0);

    // Active-low pad on the second instance.
    rst = 1'b0;
    button_n = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      cycle(1'b0);
      chk("t6_idle_step", step_n, 1'b0);
      chk("t6_idle_level", level_n, 1'b0);
      chk("t6_idle_release", release_n, 1'b0);
    end
    button_n = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      cycle(1'b0);
      chk("t6_press_edge", press_n, e == 7);
      chk("t6_level", level_n, e >= 7);
      chk("t6_step", step_n, e == 7);
    end

    // Random segments: short bounces and long holds against the model.
    for (int seg = 0; seg < 80; seg++) begin
      logic b;
      int   len;
      b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = int'($urandom_range(20, 45));
      else len = int'($urandom_range(1, 8));
      repeat (len) begin
        cycle(b);
        chk("rand_release_excl", release_pulse & step, 1'b0);
      end
    end
    repeat (10) cycle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_press_conditioner.md
Name: button_press_conditioner

Overview:
- Upstream conditioning stage for the push-button LED counter.
- Synchronises a raw mechanical button and debounces it with a state machine.
- Emits single-cycle press, release, long-press and auto-repeat pulses, plus a merged `step` pulse.
- The downstream counter consumes `step` as a clock-enable in the `clk` domain instead of clocking on the raw button.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops, minimum 2.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a press or a release, minimum 1.
- LONG_PRESS_CYCLES, 25000000: cycles held in HELD before `long_press` fires; 0 disables long-press and repeat.
- REPEAT_CYCLES, 5000000: period of `repeat_pulse` while in REPEAT, minimum 1.
- ACTIVE_LOW_BUTTON, 0: 1 means the pad reads 0 when pressed; the input is inverted before the synchroniser.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- button  input  1  raw, asynchronous, bouncy button pad.
- level  output  1  debounced pressed state.
- press_pulse  output  1  one-cycle pulse on accepted press.
- release_pulse  output  1  one-cycle pulse on accepted release.
- long_press  output  1  one-cycle pulse when the hold threshold is reached.
- repeat_pulse  output  1  one-cycle pulse each repeat period.
- step  output  1  press_pulse | long_press | repeat_pulse, registered in the same cycle.

Behaviour:
- Clock and reset (already decided): one clock, `clk`. Reset `rst` is asynchronous, active-low; `rst` = 0 clears every flop immediately.
- Reset values: all outputs 0, state IDLE, all counters 0, synchroniser flops 0, `rep_flag` 0.
- Synchroniser: `s_in` = last synchroniser stage, taken after optional polarity inversion, so `s_in` = 1 means pressed.
- Outputs: all registered. Pulse outputs are high for exactly one cycle per event.
- Counters: `db_cnt`, `hold_cnt` and `rep_cnt` are each sized to hold their parameter minus 1. None wraps; each is cleared on every state transition.
- IDLE: `level` = 0. If `s_in` = 1 -> DB_PRESS with `db_cnt` = 0.
- DB_PRESS:
  - `s_in` = 0 -> IDLE (bounce rejected, no pulse).
  - Else if `db_cnt` == DEBOUNCE_CYCLES-1 -> HELD; `level` <= 1; `press_pulse` and `step` high next cycle.
  - Else `db_cnt` increments.
- HELD:
  - `s_in` = 0 -> DB_RELEASE.
  - Else if LONG_PRESS_CYCLES != 0 and `hold_cnt` == LONG_PRESS_CYCLES-1 -> REPEAT; `long_press` and `step` pulse; `rep_flag` <= 1.
  - Else `hold_cnt` increments.
- REPEAT:
  - `s_in` = 0 -> DB_RELEASE.
  - Else if `rep_cnt` == REPEAT_CYCLES-1 -> `repeat_pulse` and `step` pulse; `rep_cnt` <= 0.
  - Else `rep_cnt` increments.
- DB_RELEASE:
  - `s_in` = 1 -> return to REPEAT if `rep_flag`, else HELD, with that state's timer cleared and no pulse.
  - Else if `db_cnt` == DEBOUNCE_CYCLES-1 -> IDLE; `level` <= 0; `release_pulse` pulse; `rep_flag` <= 0.
  - Else `db_cnt` increments.
  - `level` stays 1 throughout DB_RELEASE.
- Press latency: with `button` steady high and edge 1 the first edge sampling it high, `press_pulse` is high after edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
- Release latency: symmetric to press latency, measured from the first edge sampling `button` low.
- Long-press and repeat timing: if HELD is entered at edge P, `long_press` occurs at P+LONG_PRESS_CYCLES. Repeats follow at P+LONG_PRESS_CYCLES+k*REPEAT_CYCLES for k >= 1.
- Event exclusivity: press, long and repeat never coincide, so `step` carries at most one event per cycle. `release_pulse` never coincides with any other pulse.
- Reset mid-operation: any state aborts to IDLE with no release pulse. A button held across reset deassertion must pass a full new debounce before `press_pulse`.
- LONG_PRESS_CYCLES = 0: HELD never exits except via release; `long_press` and `repeat_pulse` stay 0.

Test Plan:
Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW_BUTTON=0.
1. Clean press: `button` 0->1 sampled at edge 1, held -> `press_pulse`/`step` high after edge 7 only, `level`=1 from edge 7. Release 15 cycles later -> `release_pulse` 7 edges after the first low sample, `level`=0.
2. Bounce reject: `button` high 3 cycles, low 1, high 2, low -> no pulses, `level` stays 0. Then high 10 cycles -> exactly one `press_pulse`.
3. Long-press and repeat: hold 40 cycles -> `press_pulse` at edge 7, `long_press` at edge 17, `repeat_pulse` at edges 20, 23, 26 and every 3 after until release; `step` counts 1 + 1 + repeats. The bench checks no `step` appears after the release debounce starts.
4. Release glitch: in REPEAT, drop `button` for 2 cycles then restore -> no `release_pulse`, `level` stays 1, repeats resume 3 cycles after return to REPEAT.
5. Async reset: assert `rst`=0 mid-REPEAT with `button` held -> all outputs 0 immediately. Deassert -> next `press_pulse` 7 edges after deassertion, with no `release_pulse` ever emitted.
6. Polarity: ACTIVE_LOW_BUTTON=1, `button` 1->0 -> `press_pulse` after edge 7; `button` idle high after reset -> no pulses.
